// File: rtl/urt_tx_frame.sv
// urt_tx_frame: UART transmit framer/serializer, one bit per CLK_URT_TX tick (start, data LSB-first, optional parity, stop).
// Optional macro URT_TX_HOLD_BUF_EN adds a one-entry holding register so frames can run back-to-back.
module urt_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_URT_TX,
  input  logic                  RST_URT_TX,
  input  logic [DATA_WIDTH-1:0] P_DATA_URT_TX,
  input  logic                  Data_Valid_URT_TX,
  input  logic                  PAR_EN_URT_TX,
  input  logic                  PAR_TYP_URT_TX,
  output logic                  TX_OUT_URT_TX,
  output logic                  busy_URT_TX
);
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  par_en_q;
  logic                  par_bit_q;

`ifdef URT_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_par_en;
  logic                  hold_par_bit;
  logic                  hold_full;
`endif

  // Even parity = XOR-reduce; odd parity = XNOR-reduce.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign shift_nxt = shift_reg >> 1;

  // Outputs are loaded with the value of the state being entered, so they stay registered.
  always_ff @(posedge CLK_URT_TX or negedge RST_URT_TX) begin
    if (!RST_URT_TX) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      TX_OUT_URT_TX <= 1'b1;
      busy_URT_TX   <= 1'b0;
`ifdef URT_TX_HOLD_BUF_EN
      hold_data     <= '0;
      hold_par_en   <= 1'b0;
      hold_par_bit  <= 1'b0;
      hold_full     <= 1'b0;
`endif
    end else begin
`ifdef URT_TX_HOLD_BUF_EN
      // STOP handles its own strobe by launching the next frame directly.
      if (Data_Valid_URT_TX && !hold_full && state != IDLE && state != STOP) begin
        hold_data    <= P_DATA_URT_TX;
        hold_par_en  <= PAR_EN_URT_TX;
        hold_par_bit <= calc_parity(P_DATA_URT_TX, PAR_TYP_URT_TX);
        hold_full    <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (Data_Valid_URT_TX) begin
            shift_reg     <= P_DATA_URT_TX;
            par_en_q      <= PAR_EN_URT_TX;
            par_bit_q     <= calc_parity(P_DATA_URT_TX, PAR_TYP_URT_TX);
            state         <= START;
            TX_OUT_URT_TX <= 1'b0;
            busy_URT_TX   <= 1'b1;
          end else begin
            TX_OUT_URT_TX <= 1'b1;
            busy_URT_TX   <= 1'b0;
          end
        end
        START: begin
          state         <= DATA;
          bit_cnt       <= '0;
          TX_OUT_URT_TX <= shift_reg[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state         <= PARITY;
              TX_OUT_URT_TX <= par_bit_q;
            end else begin
              state         <= STOP;
              TX_OUT_URT_TX <= 1'b1;
            end
          end else begin
            bit_cnt       <= bit_cnt + 1'b1;
            shift_reg     <= shift_nxt;
            TX_OUT_URT_TX <= shift_nxt[0];
          end
        end
        PARITY: begin
          state         <= STOP;
          TX_OUT_URT_TX <= 1'b1;
        end
        STOP: begin
`ifdef URT_TX_HOLD_BUF_EN
          if (hold_full) begin
            shift_reg     <= hold_data;
            par_en_q      <= hold_par_en;
            par_bit_q     <= hold_par_bit;
            hold_full     <= 1'b0;
            state         <= START;
            TX_OUT_URT_TX <= 1'b0;
          end else if (Data_Valid_URT_TX) begin
            shift_reg     <= P_DATA_URT_TX;
            par_en_q      <= PAR_EN_URT_TX;
            par_bit_q     <= calc_parity(P_DATA_URT_TX, PAR_TYP_URT_TX);
            state         <= START;
            TX_OUT_URT_TX <= 1'b0;
          end else begin
            state         <= IDLE;
            TX_OUT_URT_TX <= 1'b1;
            busy_URT_TX   <= 1'b0;
          end
`else
          state         <= IDLE;
          TX_OUT_URT_TX <= 1'b1;
          busy_URT_TX   <= 1'b0;
`endif
        end
        default: begin
          state         <= IDLE;
          TX_OUT_URT_TX <= 1'b1;
          busy_URT_TX   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/urt_tx_frame.md
Name: urt_tx_frame

Overview:
- UART transmit-side framer and serializer: the counterpart of the RX sampler/parity-check chain.
- Accepts a parallel word with a valid strobe and emits one frame, one bit per clock: start, data LSB-first, optional parity, stop.
- CLK_URT_TX is the TX baud clock, one tick per bit; no oversampling.
- Sits between the system-side data source and the serial line.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and number of data bits per frame

Ports:
CLK_URT_TX  input  1  baud-rate clock, rising-edge
RST_URT_TX  input  1  asynchronous active-low reset
P_DATA_URT_TX  input  DATA_WIDTH  parallel data to transmit
Data_Valid_URT_TX  input  1  single-cycle strobe qualifying P_DATA_URT_TX
PAR_EN_URT_TX  input  1  1 = parity bit inserted after data
PAR_TYP_URT_TX  input  1  0 = even parity, 1 = odd parity
TX_OUT_URT_TX  output  1  serial line, idle high
busy_URT_TX  output  1  high while a frame is in flight

Behaviour:
- Clock and reset: single clock CLK_URT_TX; reset RST_URT_TX asynchronous, active-low.
- Reset values:
  - TX_OUT_URT_TX = 1, busy_URT_TX = 0.
  - State = IDLE; bit counter = 0; shift/hold registers = 0.
- Outputs are registered, with no combinational path from inputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT = 1, busy = 0.
  - On an edge with Data_Valid = 1: latch P_DATA, PAR_EN and PAR_TYP into internal registers, then go to START.
- START: TX_OUT = 0, busy = 1; next state DATA, counter cleared.
- DATA:
  - TX_OUT = latched data[counter], LSB first.
  - The counter increments each cycle; after bit DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else STOP.
- PARITY:
  - Parity is computed once from the latched data at acceptance.
  - Even: TX_OUT = XOR-reduce(data). Odd: TX_OUT = XNOR-reduce(data).
  - Next state STOP.
- STOP: TX_OUT = 1, busy = 1; next state IDLE.
- Timing:
  - Data_Valid sampled at edge N → start bit visible after edge N, data bit 0 after edge N+1.
  - Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 with parity.
  - busy rises after edge N and falls after the edge that leaves STOP.
- Config inputs (PAR_EN, PAR_TYP, P_DATA) changing mid-frame have no effect; only values latched at acceptance are used.
- Data_Valid while busy = 1 (base build): ignored, with no queueing and no frame corruption.
- Back-to-back frames (base build): at least one IDLE cycle (TX_OUT = 1) separates them.
- Reset asserted mid-frame: immediately TX_OUT = 1, busy = 0, state IDLE; the partial frame is dropped and not resumed.
- Counter width: $clog2(DATA_WIDTH), minimum 1 bit; no wrap beyond DATA_WIDTH-1.

Optional Feature:
URT_TX_HOLD_BUF_EN
- Defined:
  - Adds a one-entry holding register plus a hold_full flag (reset 0).
  - Data_Valid while busy with hold_full = 0: captures data, PAR_EN and PAR_TYP; hold_full set. With hold_full = 1: ignored.
  - In STOP with hold_full = 1: next state START directly; the held word moves to the shift register and hold_full clears. No idle gap between frames; busy stays high.
  - Data_Valid in STOP with hold_full = 0: captured into hold, so the next frame follows back-to-back.
  - Reset clears hold_full.
- Undefined: no holding register; base-build behaviour.

Test Plan:
- Frame 0xA5, PAR_EN = 1, PAR_TYP = 0, strobe at edge N:
  - TX_OUT after edges N..N+10 = 0,1,0,1,0,0,1,0,1,0,1.
  - busy high for 11 cycles, then 0.
- Frame 0xA5, PAR_EN = 1, PAR_TYP = 1: same as above except the parity bit = 1.
- Frame 0x00, PAR_EN = 0: TX_OUT = 0 for 9 cycles, then 1; busy high for exactly 10 cycles; no parity slot.
- Change P_DATA to 0xFF and PAR_TYP mid-frame of 0x3C (PAR_EN = 1, PAR_TYP = 0), and pulse Data_Valid at data bit 3:
  - Frame 0x3C is unchanged and its parity bit = 0.
  - Base build: no second frame follows.
- Assert RST low during data bit 4 of 0x81: TX_OUT = 1 and busy = 0 asynchronously. After release, line idle until a new strobe; the new frame 0x55 is correct from its start bit.
- URT_TX_HOLD_BUF_EN defined: strobe 0x12, then 0x34 during its DATA state, PAR_EN = 0:
  - Start bit of 0x34 follows the stop bit of 0x12 with zero idle cycles; busy high for 20 cycles.
  - A third strobe while hold_full = 1 is dropped.
